// File: rtl/adder_result_stage.sv
// Registered result stage behind full_adder_16: captures sum/operands, derives C/Z/N/V flags,
// buffers them behind valid/ready and tracks carry exceptions. `ADDER_RESULT_SKID_EN selects 2-entry skid.
module adder_result_stage #(
  parameter int EXC_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          inp1,
  input  logic [15:0]          inp2,
  input  logic [15:0]          sum,
  input  logic                 cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          res,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_v,
  output logic                 exc,
  input  logic                 exc_clr,
  output logic [EXC_CNT_W-1:0] exc_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic        v;
    logic        n;
    logic        z;
    logic        c;
    logic [15:0] r;
  } entry_t;

  localparam logic [EXC_CNT_W-1:0] CNT_MAX = {EXC_CNT_W{1'b1}};
  localparam logic [EXC_CNT_W-1:0] CNT_ONE = EXC_CNT_W'(1'b1);

  function automatic entry_t make_entry(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] s, input logic co);
    entry_t e;
    e.r = s;
    e.c = co;
    e.z = (s == 16'h0000);
    e.n = s[15];
    e.v = (a[15] == b[15]) && (s[15] != a[15]);
    return e;
  endfunction

  state_t               state_r;
  entry_t               head_r;
  logic                 exc_r;
  logic [EXC_CNT_W-1:0] cnt_r;
  entry_t               new_s;
  logic                 accept_s;
  logic                 pop_s;
  logic                 event_s;

  assign new_s     = make_entry(inp1, inp2, sum, cout);
  assign out_valid = (state_r != EMPTY);
`ifdef ADDER_RESULT_SKID_EN
  assign in_ready  = (state_r != FULL);
`else
  assign in_ready  = (state_r == EMPTY) || out_ready;
`endif
  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign event_s   = accept_s && cout;

  assign res     = head_r.r;
  assign flag_c  = head_r.c;
  assign flag_z  = head_r.z;
  assign flag_n  = head_r.n;
  assign flag_v  = head_r.v;
  assign exc     = exc_r;
  assign exc_cnt = cnt_r;

`ifdef ADDER_RESULT_SKID_EN
  entry_t tail_r;

  // Occupancy FSM for the 2-entry skid buffer; head_r always drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_r  <= new_s;
            state_r <= ONE;
          end
        end
        ONE: begin
          if (accept_s && !pop_s) begin
            tail_r  <= new_s;
            state_r <= FULL;
          end else if (accept_s && pop_s) begin
            head_r  <= new_s;
          end else if (pop_s) begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_r  <= tail_r;
            state_r <= ONE;
          end
        end
        default: state_r <= EMPTY;
      endcase
    end
  end
`else
  // Single-entry holding register; a refill is only possible alongside a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      head_r  <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_r  <= new_s;
            state_r <= ONE;
          end
        end
        ONE: begin
          if (accept_s) begin
            head_r  <= new_s;
          end else if (pop_s) begin
            state_r <= EMPTY;
          end
        end
        default: state_r <= EMPTY;
      endcase
    end
  end
`endif

  // Sticky exception and saturating carry counter; a clear never masks a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_r <= 1'b0;
      cnt_r <= '0;
    end else if (exc_clr) begin
      exc_r <= event_s;
      cnt_r <= event_s ? CNT_ONE : '0;
    end else if (event_s) begin
      exc_r <= 1'b1;
      cnt_r <= (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage with a queue-based reference model checked every cycle.
module tb_adder_result_stage;

  localparam int W = 2;
`ifdef ADDER_RESULT_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         exc_clr = 1'b0;
  logic         cout = 1'b0;
  logic [15:0]  inp1 = 16'h0000;
  logic [15:0]  inp2 = 16'h0000;
  logic [15:0]  sum = 16'h0000;
  logic         in_ready, out_valid, flag_c, flag_z, flag_n, flag_v, exc;
  logic [15:0]  res;
  logic [W-1:0] exc_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_result_stage #(.EXC_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .exc(exc), .exc_clr(exc_clr), .exc_cnt(exc_cnt)
  );

  typedef struct {
    logic [15:0] r;
    logic        c, z, n, v;
  } ent_t;

  ent_t        q[$];
  logic        exc_m = 1'b0;
  int          cnt_m = 0;
  logic [15:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flags from integer arithmetic: overflow means the true signed sum left 16-bit range.
  function automatic ent_t predict(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] s, input logic co);
    ent_t e;
    int   t;
    t   = int'($signed(a)) + int'($signed(b));
    e.r = s;
    e.c = co;
    e.z = (s == 16'h0000);
    e.n = s[15];
    e.v = (t > 32767) || (t < -32768);
    return e;
  endfunction

  function automatic logic model_rdy();
`ifdef ADDER_RESULT_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  // Reference model update on each clock edge; reset empties it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exc_m = 1'b0;
      cnt_m = 0;
    end else begin
      logic acc, pop, ev;
      acc = in_valid && model_rdy();
      pop = (q.size() != 0) && out_ready;
      ev  = acc && cout;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(predict(inp1, inp2, sum, cout));
      if (exc_clr) begin
        exc_m = ev;
        cnt_m = ev ? 1 : 0;
      end else if (ev) begin
        exc_m = 1'b1;
        cnt_m = (cnt_m + 1 > (1 << W) - 1) ? (1 << W) - 1 : cnt_m + 1;
      end
    end
  end

  // Per-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, model_rdy());
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("res", res, q[0].r);
        chk("flags_cznv", {flag_c, flag_z, flag_n, flag_v}, {q[0].c, q[0].z, q[0].n, q[0].v});
      end
      chk("exc", exc, exc_m);
      chk("exc_cnt", exc_cnt, cnt_m);
      if (out_valid && out_ready) got.push_back(res);
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    {cout, sum} = {1'b0, a} + {1'b0, b};
    inp1 = a;
    inp2 = b;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    drive(a, b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int          idx;
    int          cyc;
    logic        rdy;
    logic [15:0] item_a;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res", res, 16'h0000);
    chk("rst_flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0000);
    chk("rst_exc", {exc, exc_cnt}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(16'h0003, 16'h0004);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_res", res, 16'h0007);
    chk("basic_flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0000);
    chk("basic_exc", exc, 1'b0);

    send(16'hFFFF, 16'h0001);
    chk("cz_res", res, 16'h0000);
    chk("cz_flags", {flag_c, flag_z, flag_v}, 3'b110);
    chk("cz_exc", {exc, exc_cnt}, 3'b101);

    exc_clr = 1'b1;
    @(posedge clk);
    #1;
    exc_clr = 1'b0;
    chk("clr_alone", {exc, exc_cnt}, 3'b000);

    send(16'h7FFF, 16'h0001);
    chk("ovf_res", res, 16'h8000);
    chk("ovf_flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0011);
    chk("ovf_exc", exc, 1'b0);

    send(16'h8000, 16'hFFFE);
    chk("sub_res", res, 16'h7FFE);
    chk("sub_flags", {flag_c, flag_z, flag_n, flag_v}, 4'b1001);
    chk("sub_exc", {exc, exc_cnt}, 3'b101);

    for (int k = 0; k < 4; k++) send(16'hFFFF, 16'h0002);
    chk("sat_cnt", {exc, exc_cnt}, 3'b111);

    exc_clr = 1'b1;
    send(16'hFFFF, 16'h0001);
    exc_clr = 1'b0;
    chk("clr_with_event", {exc, exc_cnt}, 3'b101);
    exc_clr = 1'b1;
    @(posedge clk);
    #1;
    exc_clr = 1'b0;
    chk("clr_alone2", {exc, exc_cnt}, 3'b000);

    // Backpressure: three results offered while the consumer stalls, then drained.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    got.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 3 || out_valid) && cyc < 24) begin
      if (cyc == 4) begin
        chk("bp_accepted", idx, CAP);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head", res, 16'h0101);
        out_ready = 1'b1;
      end
      if (idx < 3) begin
        item_a = 16'h0100 + 16'(idx * 17);
        drive(item_a, 16'h0001);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy && in_valid) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_drained", (idx == 3) && !out_valid, 1'b1);
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) chk("bp_order", got[k], 16'h0101 + 16'(k * 17));
    end

    // Asynchronous reset while the buffer is full.
    out_ready = 1'b0;
    drive(16'hFFFF, 16'h0001);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_full", {out_valid, in_ready, exc}, 3'b101);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_exc", {exc, exc_cnt}, 3'b000);
    chk("arst_res", res, 16'h0000);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h1234, 16'h1111);
    chk("post_rst_res", {out_valid, res}, {1'b1, 16'h2345});

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
